// File: rtl/machine_heap_pkg.sv
// machine_heap_pkg: shared widths, request op codes, response tags and FSM
// state encoding for the SKI machine heap cell store.
package machine_heap_pkg;

  localparam int TERM_W  = 63;
  localparam int CELL_W  = 126;
  localparam int HADDR_W = 30;
  localparam int RESP_W  = 128;

  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_READ_ONE  = 2'b01,
    OP_READ_PAIR = 2'b10,
    OP_WRITE     = 2'b11
  } op_e;

  localparam logic [1:0] TAG_NONE = 2'b00;
  localparam logic [1:0] TAG_ONE  = 2'b01;
  localparam logic [1:0] TAG_PAIR = 2'b10;
  localparam logic [1:0] TAG_ERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_IDLE  = 2'b01,
    ST_RD    = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/machine_heap_if.sv
// machine_heap_if: request/response handshake bundle between the machine's
// sequential wrapper (master) and the heap store (slave).
//   req_valid/req_ready/req_op/req_addr/req_wdata : request channel
//   resp_valid/resp_ready/resp                     : response channel
interface machine_heap_if;
  import machine_heap_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [HADDR_W-1:0]  req_addr;
  logic [CELL_W-1:0]   req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [RESP_W-1:0]   resp;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp
  );

endinterface

// File: rtl/machine_heap_ram.sv
// machine_heap_ram: single-port synchronous cell RAM, 2**DEPTH_LOG2 x 126,
// read-first with a registered (1-cycle) read port. No reset on storage.
//   i_clk   : clock
//   i_we    : write enable
//   i_addr  : cell address
//   i_wdata : {left, right} cell contents to write
//   o_rdata : cell contents at the address sampled on the previous edge
module machine_heap_ram
  import machine_heap_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [CELL_W-1:0]     i_wdata,
  output logic [CELL_W-1:0]     o_rdata
);

  logic [CELL_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/machine_heap.sv
// machine_heap: heap cell store feeding the SKI machine step function.
// Clears all cells after reset, then services one read at a time and
// single-cycle application-cell writes.
//   system1000      : clock
//   system1000_rstn : asynchronous active-low reset
//   bus (slave)     : request channel (NOP/READ_ONE/READ_PAIR/WRITE) and
//                     128-bit response channel {tag, t0, t1}
module machine_heap
  import machine_heap_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic         system1000,
  input  logic         system1000_rstn,
  machine_heap_if.slave bus
);

  state_e                r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_clr_addr;
  op_e                   r_op;
  logic                  r_err;
  logic [RESP_W-1:0]     r_resp;

  op_e                   w_op;
  logic                  w_accept;
  logic                  w_oor;
  logic                  w_ram_we;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic [CELL_W-1:0]     w_ram_wdata;
  logic [CELL_W-1:0]     w_ram_rdata;

  assign w_op     = op_e'(bus.req_op);
  assign w_accept = bus.req_valid && (r_state == ST_IDLE);
  // Any set bit above the implemented index range is a range error.
  assign w_oor    = (bus.req_addr >> DEPTH_LOG2) != '0;

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp       = r_resp;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) r_state <= ST_CLEAR;
    else                  r_state <= w_state_nxt;
  end

  // Next state plus the RAM port mux: the clear sweep owns the port in CLEAR,
  // otherwise the request address drives it so a read is launched on accept.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    w_ram_addr  = bus.req_addr[DEPTH_LOG2-1:0];
    w_ram_wdata = bus.req_wdata;
    case (r_state)
      ST_CLEAR: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_clr_addr;
        w_ram_wdata = '0;
        if (&r_clr_addr) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_WRITE:                  w_ram_we    = !w_oor;
            OP_READ_ONE, OP_READ_PAIR: w_state_nxt = ST_RD;
            default:                   w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_RD:   w_state_nxt = ST_RESP;
      ST_RESP: if (bus.resp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_clr_addr <= '0;
      r_op       <= OP_NOP;
      r_err      <= 1'b0;
      r_resp     <= '0;
    end else begin
      if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      if (w_accept && (w_op == OP_READ_ONE || w_op == OP_READ_PAIR)) begin
        r_op  <= w_op;
        r_err <= w_oor;
      end
      if (r_state == ST_RD) begin
        if (r_err)
          r_resp <= {TAG_ERR, {CELL_W{1'b0}}};
        else if (r_op == OP_READ_ONE)
          r_resp <= {TAG_ONE, w_ram_rdata[CELL_W-1:TERM_W], {TERM_W{1'b0}}};
        else
          r_resp <= {TAG_PAIR, w_ram_rdata};
      end else if (r_state == ST_RESP && bus.resp_ready) begin
        r_resp <= '0;
      end
    end
  end

  machine_heap_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .i_clk   (system1000),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: doc/machine_heap.md
# machine_heap

Heap cell store for the SKI reduction machine. It sits directly upstream of the machine step function and produces the 128-bit heap response word that the step function consumes: 2-bit tag, then two 63-bit terms. It services one outstanding read at a time from the machine's sequential wrapper and accepts application-cell writes. After reset it clears its storage before accepting any request.

## Interface
- `DEPTH_LOG2`, default 10: log2 of heap cells implemented; legal addresses are `0 .. 2**DEPTH_LOG2-1`.
- `system1000`, in, 1: clock.
- `system1000_rstn`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted on an edge where `req_valid && req_ready`.
- `req_op`, in, 2: 00 NOP, 01 READ_ONE, 10 READ_PAIR, 11 WRITE.
- `req_addr`, in, 30: heap address (machine heap-pointer width).
- `req_wdata`, in, 126: `{left[62:0], right[62:0]}`; used by WRITE only.
- `resp_valid`, out, 1: response word valid.
- `resp_ready`, in, 1: consumer takes the response on an edge where `resp_valid && resp_ready`.
- `resp`, out, 128: `{tag[1:0], t0[62:0], t1[62:0]}`.

## Operation
- States: CLEAR, IDLE, RD, RESP.
- CLEAR (entered on reset):
  - 10-bit counter `clr_addr` writes cell = 0 at addresses 0..DEPTH-1, one per cycle.
  - Moves to IDLE on the edge that writes DEPTH-1; the sweep lasts exactly DEPTH cycles.
  - `req_ready` = 0.
- IDLE:
  - `req_ready` = 1.
  - NOP: consumed, no effect.
  - WRITE, in range: cell[addr] ← `req_wdata` on the accept edge. No response. State stays IDLE, so back-to-back writes run at one per cycle.
  - WRITE, out of range (`req_addr >= 2**DEPTH_LOG2`): dropped silently.
  - READ_ONE / READ_PAIR: RAM address driven from `req_addr` on the accept edge. Op and range-error flag are captured. Next state RD.
- RD:
  - `req_ready` = 0.
  - On the next edge, load `resp`:
    - Range error: `{2'b11, 126'b0}`.
    - READ_ONE: `{2'b01, left, 63'b0}`.
    - READ_PAIR: `{2'b10, left, right}`.
  - Next state RESP.
- RESP:
  - `resp_valid` = 1; `resp` is held stable until the handshake.
  - On the handshake edge: `resp_valid` → 0, `resp` → 0, next state IDLE.
- A request is never accepted in RD, RESP or CLEAR.
- Address width rule: only `req_addr[DEPTH_LOG2-1:0]` indexes the RAM. Upper bits are checked only to detect a range error.
- Term tag bits `[62:60]` are stored opaquely; no term decoding happens here.

## Timing
- Reset values: `req_ready` 0, `resp_valid` 0, `resp` 0, state CLEAR, `clr_addr` 0. RAM contents are undefined until the sweep completes.
- Reset asserted mid-operation:
  - Any in-flight read is discarded with no response.
  - `resp_valid` drops asynchronously.
  - The sweep restarts from 0 after deassertion.
- Read latency: read accepted at edge k → `resp_valid` high after edge k+1.
- Minimum read-to-read spacing is 3 cycles: accept, RD, RESP with immediate `resp_ready`.
- Read-after-write: WRITE at edge k, READ accepted at edge k+1 or later returns the new data.
- Back-pressure: with `resp_ready` low, RESP holds indefinitely and `resp` does not change.
- `req_ready` is a function of state only; it never depends combinationally on `req_valid`.

## Structure
- Shared package `machine_heap_pkg`, holding:
  - `TERM_W` = 63, `CELL_W` = 126, `HADDR_W` = 30, `RESP_W` = 128.
  - Op codes `OP_NOP/OP_READ_ONE/OP_READ_PAIR/OP_WRITE`.
  - Response tags `TAG_NONE`=00, `TAG_ONE`=01, `TAG_PAIR`=10, `TAG_ERR`=11.
  - State encoding.
- One sub-module, `machine_heap_ram`: single-port synchronous RAM, `2**DEPTH_LOG2 × 126`, with one write enable and a registered read (1 cycle), no reset.
- The top level holds the FSM, the clear counter, the op/error capture registers and the response register. The clear-sweep write mux drives the RAM port.

## Test plan
- Reset, then hold `req_valid` = 1 with NOP → `req_ready` stays 0 for exactly 1024 cycles, then rises. READ_PAIR at 0x3FF → `resp` = `{2'b10, 126'b0}`.
- WRITE addr 5 with left = `63'h3000_0000_0000_0007`, right = `63'h1`, then READ_PAIR addr 5 on the next cycle → `resp` = `{2'b10, 63'h3000_0000_0000_0007, 63'h1}` one edge after accept.
- READ_ONE addr 5 → `resp` = `{2'b01, 63'h3000_0000_0000_0007, 63'b0}`.
- READ_PAIR addr 30'd1024 → `resp` = `{2'b11, 126'b0}`. A WRITE to 30'd2048 leaves cell 0 unchanged (verified by READ_PAIR 0).
- Read with `resp_ready` low for 20 cycles → `resp_valid`/`resp` stable and `req_ready` 0 throughout. The handshake returns the FSM to IDLE and `req_ready` = 1 on the following cycle.
- Assert `system1000_rstn` low while in RD → `resp_valid` never rises. A new full clear sweep follows, and previously written cell 5 reads back 0.
